// File: rtl/stopwatch_ctrl.sv
// Stopwatch button front-end: sync + debounce + edge detect per button, then a sequencing FSM.
// Latency: button stable from edge E -> registered pulse after edge E+DB_CYCLES+3. No backpressure; ignored events are dropped.
// Optional macro LAP_TIMEOUT_EN: LAP auto-resumes to RUN after LAP_HOLD_CYCLES cycles.
module stopwatch_ctrl #(
    parameter int DB_CYCLES       = 16,
    parameter int LAP_HOLD_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_startstop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       start,
    output logic       stop,
    output logic       midstop,
    output logic       clear,
    output logic [1:0] state
);

    localparam int CW = $clog2(DB_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAP    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    if (DB_CYCLES < 2 || LAP_HOLD_CYCLES < 1) begin : g_bad_param
        $error("stopwatch_ctrl: DB_CYCLES must be >= 2 and LAP_HOLD_CYCLES >= 1");
    end

    // Button index: 0 startstop, 1 lap, 2 clear
    logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]         db_q, db_d, db_prev_q, db_prev_d, evt_q, evt_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;

    state_t state_q, state_d;
    logic   start_q, start_d, stop_q, stop_d, midstop_q, midstop_d, clear_q, clear_d;

    always_comb begin
        sync1_d   = {btn_clear, btn_lap, btn_startstop};
        sync2_d   = sync1_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        db_prev_d = db_q;
        evt_d     = db_q & ~db_prev_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

`ifdef LAP_TIMEOUT_EN
    localparam int TW = $clog2(LAP_HOLD_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          lap_expired;

    assign lap_expired = (timer_q >= TW'(LAP_HOLD_CYCLES - 1));
`endif

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        midstop_d = 1'b0;
        clear_d   = 1'b0;
        unique case (state_q)
            IDLE, PAUSED: begin
                if (evt_q == 3'b001) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end else if (evt_q == 3'b100) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
            end
            RUN: begin
                if (evt_q == 3'b001) begin
                    state_d = PAUSED;
                    stop_d  = 1'b1;
                end else if (evt_q == 3'b010) begin
                    state_d   = LAP;
                    midstop_d = 1'b1;
                end
            end
            LAP: begin
                if (evt_q == 3'b010) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end else if (evt_q == 3'b001) begin
                    state_d = PAUSED;
                    stop_d  = 1'b1;
                end
`ifdef LAP_TIMEOUT_EN
                // Auto-resume only when no user event arrives this cycle
                else if (evt_q == 3'b000 && lap_expired) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LAP_TIMEOUT_EN
    always_comb begin
        timer_d = '0;
        if (state_q == LAP && state_d == LAP && !lap_expired) begin
            timer_d = timer_q + TW'(1);
        end else if (state_q == LAP && state_d == LAP) begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            evt_q     <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            midstop_q <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            evt_q     <= evt_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            midstop_q <= midstop_d;
            clear_q   <= clear_d;
        end
    end

    assign start   = start_q;
    assign stop    = stop_q;
    assign midstop = midstop_q;
    assign clear   = clear_q;
    assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DB_CYCLES=4, LAP_HOLD_CYCLES=8.
// Define LAP_TIMEOUT_EN for both RTL and bench to exercise the LAP auto-resume.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_startstop = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clear = 1'b0;
    logic       start, stop, midstop, clear;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-window pulse statistics; cycle k counts edges since the window began
    int cnt_s, cnt_p, cnt_m, cnt_c, first_s, first_p, first_m, first_c, multi;

    stopwatch_ctrl #(
        .DB_CYCLES      (4),
        .LAP_HOLD_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_startstop(btn_startstop),
        .btn_lap      (btn_lap),
        .btn_clear    (btn_clear),
        .start        (start),
        .stop         (stop),
        .midstop      (midstop),
        .clear        (clear),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive button mask b (bit0 startstop, bit1 lap, bit2 clear) sampled from the next
    // edge (k=1) for 'hold' edges, then watch n cycles in total.
    task automatic drive(input logic [2:0] b, input int hold, input int n);
        {btn_clear, btn_lap, btn_startstop} = b;
        cnt_s = 0; cnt_p = 0; cnt_m = 0; cnt_c = 0;
        first_s = 0; first_p = 0; first_m = 0; first_c = 0; multi = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == hold) {btn_clear, btn_lap, btn_startstop} = 3'b000;
            if (start)   begin cnt_s++; if (first_s == 0) first_s = k; end
            if (stop)    begin cnt_p++; if (first_p == 0) first_p = k; end
            if (midstop) begin cnt_m++; if (first_m == 0) first_m = k; end
            if (clear)   begin cnt_c++; if (first_c == 0) first_c = k; end
            if (int'(start) + int'(stop) + int'(midstop) + int'(clear) > 1) multi++;
        end
    endtask

    function automatic int pulses();
        return {28'd0, start, stop, midstop, clear};
    endfunction

    initial begin
        // T1: reset and quiet period
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t1_rst_pulses", pulses(), 0);
            check_eq("t1_rst_state", int'(state), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("t1_idle_pulses", pulses(), 0);
            check_eq("t1_idle_state", int'(state), 0);
        end

        // T2: held startstop -> one start pulse 7 edges after first sampling edge
        drive(3'b001, 12, 24);
        check_eq("t2_start_cnt", cnt_s, 1);
        check_eq("t2_start_cycle", first_s, 8);
        check_eq("t2_other_pulses", cnt_p + cnt_m + cnt_c, 0);
        check_eq("t2_state", int'(state), 1);

        // T3: lap glitch, then real lap presses
        drive(3'b010, 3, 16);
        check_eq("t3_glitch_pulses", cnt_s + cnt_p + cnt_m + cnt_c, 0);
        check_eq("t3_glitch_state", int'(state), 1);
        drive(3'b010, 6, 20);
        check_eq("t3_midstop_cnt", cnt_m, 1);
        check_eq("t3_midstop_cycle", first_m, 8);
        check_eq("t3_lap_state", int'(state), 2);
        drive(3'b010, 6, 20);
        check_eq("t3_resume_start", cnt_s, 1);
        check_eq("t3_resume_midstop", cnt_m, 0);
        check_eq("t3_resume_state", int'(state), 1);

        // T4: stop, clear, then clear ignored in RUN
        drive(3'b001, 6, 20);
        check_eq("t4_stop_cnt", cnt_p, 1);
        check_eq("t4_stop_cycle", first_p, 8);
        check_eq("t4_paused_state", int'(state), 3);
        drive(3'b100, 6, 20);
        check_eq("t4_clear_cnt", cnt_c, 1);
        check_eq("t4_clear_cycle", first_c, 8);
        check_eq("t4_clear_state", int'(state), 0);
        drive(3'b001, 6, 20);
        check_eq("t4_restart_cnt", cnt_s, 1);
        check_eq("t4_restart_state", int'(state), 1);
        drive(3'b100, 6, 20);
        check_eq("t4_clear_run_pulses", cnt_s + cnt_p + cnt_m + cnt_c, 0);
        check_eq("t4_clear_run_state", int'(state), 1);

        // T5: simultaneous events ignored; reset during debounce
        drive(3'b011, 6, 20);
        check_eq("t5_simul_pulses", cnt_s + cnt_p + cnt_m + cnt_c, 0);
        check_eq("t5_simul_state", int'(state), 1);
        btn_startstop = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        btn_startstop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("t5_rst_pulses", pulses(), 0);
            check_eq("t5_rst_state", int'(state), 0);
        end
        rst = 1'b0;
        drive(3'b000, 0, 20);
        check_eq("t5_post_rst_pulses", cnt_s + cnt_p + cnt_m + cnt_c, 0);
        check_eq("t5_post_rst_state", int'(state), 0);

        // T6: LAP auto-resume (or absence of it)
        drive(3'b001, 6, 20);
        check_eq("t6_run_state", int'(state), 1);
`ifdef LAP_TIMEOUT_EN
        drive(3'b010, 6, 30);
        check_eq("t6_midstop_cycle", first_m, 8);
        check_eq("t6_auto_start_cnt", cnt_s, 1);
        check_eq("t6_auto_start_cycle", first_s, 16);
        check_eq("t6_auto_state", int'(state), 1);
`else
        drive(3'b010, 6, 100);
        check_eq("t6_midstop_cnt", cnt_m, 1);
        check_eq("t6_no_auto_start", cnt_s, 0);
        check_eq("t6_lap_hold_state", int'(state), 2);
`endif
        check_eq("t6_exclusive", multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
